// File: rtl/mbox_fetch_sequencer.sv
// Multi-beat address sequencer for the message-box fetch path (valid/ready request channel).
// Define FETCH_OVF_CHK_EN to reject starts whose last beat address would exceed the address space.
module mbox_fetch_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 8,
    parameter int STRIDE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    fetch_count,
    input  logic [STRIDE_W-1:0] stride,
    input  logic                abort,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [CNT_W-1:0]    issued,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FIN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [STRIDE_W-1:0]   stride_q, stride_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  err_q, err_d;
    logic                  reject;
    logic [ADDR_W-1:0]     stride_ext;

    assign stride_ext = ADDR_W'(stride_q);

`ifdef FETCH_OVF_CHK_EN
    // Wide enough that base + (count-1)*stride can never wrap.
    localparam int PROD_W = ADDR_W + CNT_W + STRIDE_W + 1;
    logic [PROD_W-1:0] last_addr;
    logic [CNT_W-1:0]  count_m1;

    always_comb begin
        count_m1  = fetch_count - CNT_W'(1);
        last_addr = PROD_W'(base_addr) + PROD_W'(count_m1) * PROD_W'(stride);
        reject    = (fetch_count != '0) && (last_addr > PROD_W'({ADDR_W{1'b1}}));
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        stride_d  = stride_q;
        issued_d  = issued_q;
        aborted_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = base_addr;
                        count_d  = fetch_count;
                        stride_d = stride;
                        issued_d = '0;
                        state_d  = (fetch_count == '0) ? ST_FIN : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // req_valid is always high here, so req_ready alone marks a handshake.
                if (req_ready) begin
                    issued_d = issued_q + CNT_W'(1);
                    addr_d   = addr_q + stride_ext;
                end
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (req_ready && (issued_d == count_q)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            stride_q  <= '0;
            issued_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            stride_q  <= stride_d;
            issued_q  <= issued_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign req_valid = valid_q;
    assign req_addr  = addr_q;
    assign issued    = issued_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mbox_fetch_sequencer.sv
// Self-checking bench for mbox_fetch_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a sequence-level reference model.
module tb_mbox_fetch_sequencer;

    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 8;
    localparam int STRIDE_W = 16;
`ifdef FETCH_OVF_CHK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [CNT_W-1:0]    fetch_count = '0;
    logic [STRIDE_W-1:0] stride = '0;
    logic                abort = 1'b0;
    logic                req_ready = 1'b0;
    logic                req_valid;
    logic [ADDR_W-1:0]   req_addr;
    logic [CNT_W-1:0]    issued;
    logic                busy;
    logic                done;
    logic                aborted;
    logic                err;

    mbox_fetch_sequencer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE_W(STRIDE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .fetch_count(fetch_count), .stride(stride), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .issued(issued), .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = idle, 1 = beats outstanding, 2 = completion cycle.
    int              m_phase = 0;
    longint unsigned m_base = 0;
    longint unsigned m_stride = 0;
    int              m_cnt = 0;
    int              m_issued = 0;
    bit              m_aborted = 1'b0;
    bit              m_err = 1'b0;

    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    int cyc, done_cyc, err_cyc, n_done, n_abort, n_err, n_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name);
        check({name, " beats"}, 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < log_q.size())
                check($sformatf("%s beat%0d", name, i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_obs();
        log_q.delete();
        cyc = 0; done_cyc = -1; err_cyc = -1;
        n_done = 0; n_abort = 0; n_err = 0; n_valid = 0;
    endtask

    task automatic compare_model();
        logic [31:0] exp_addr;
        check("req_valid", 64'(req_valid), 64'(m_phase == 1));
        if (m_phase == 1) begin
            exp_addr = 32'(m_base + longint'(m_issued) * m_stride);
            check("req_addr", 64'(req_addr), 64'(exp_addr));
        end
        check("issued", 64'(issued), 64'(m_issued));
        check("busy", 64'(busy), 64'(m_phase != 0));
        check("done", 64'(done), 64'(m_phase == 2));
        check("aborted", 64'(aborted), 64'(m_aborted));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic model_update();
        logic [63:0] last;
        bit          rej;
        m_aborted = 1'b0;
        m_err     = 1'b0;
        case (m_phase)
            0: if (start) begin
                last = 64'(base_addr) + (64'(fetch_count) - 64'd1) * 64'(stride);
                rej  = OVF_EN && (fetch_count != 0) && (last > 64'hFFFF_FFFF);
                if (rej) begin
                    m_err = 1'b1;
                end else begin
                    m_base   = 64'(base_addr);
                    m_stride = 64'(stride);
                    m_cnt    = int'(fetch_count);
                    m_issued = 0;
                    m_phase  = (m_cnt == 0) ? 2 : 1;
                end
            end
            1: begin
                if (req_ready) m_issued++;
                if (abort) begin
                    m_phase   = 0;
                    m_aborted = 1'b1;
                end else if (m_issued == m_cnt) begin
                    m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // Called at a falling edge: drive inputs, advance the model, then check after the next rising edge.
    task automatic step(input bit s, input logic [31:0] b, input logic [7:0] c,
                        input logic [15:0] st, input bit ab, input bit rdy);
        start = s; base_addr = b; fetch_count = c; stride = st; abort = ab; req_ready = rdy;
        if (req_valid && rdy) log_q.push_back(req_addr);
        model_update();
        @(negedge clk);
        cyc++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (aborted) n_abort++;
        if (req_valid) n_valid++;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst req_valid", 64'(req_valid), 64'd0);
        check("rst req_addr", 64'(req_addr), 64'd0);
        check("rst issued", 64'(issued), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst aborted", 64'(aborted), 64'd0);
        check("rst err", 64'(err), 64'd0);
        m_phase = 0; m_issued = 0; m_aborted = 1'b0; m_err = 1'b0;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          s, ab, rdy;
        logic [31:0] b;
        logic [7:0]  c;
        logic [15:0] st;

        @(negedge clk);
        do_reset();

        // Back-to-back beats with no backpressure.
        clear_obs();
        step(1'b1, 32'h1000, 8'd4, 16'd4, 1'b0, 1'b1);
        idle(6);
        exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        check_log("t1");
        check("t1 done_cyc", 64'(done_cyc), 64'd5);
        check("t1 n_done", 64'(n_done), 64'd1);
        check("t1 issued", 64'(issued), 64'd4);

        // Three-cycle stall on the second beat.
        clear_obs();
        step(1'b1, 32'h1000, 8'd4, 16'd4, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        check("t2 stall addr", 64'(req_addr), 64'h1004);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b0);
        idle(6);
        exp_q = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        check_log("t2");
        check("t2 done_cyc", 64'(done_cyc), 64'd8);
        check("t2 n_done", 64'(n_done), 64'd1);

        // Zero-length sequence.
        clear_obs();
        step(1'b1, 32'h2000, 8'd0, 16'd4, 1'b0, 1'b1);
        idle(3);
        check("t3 done_cyc", 64'(done_cyc), 64'd1);
        check("t3 n_valid", 64'(n_valid), 64'd0);
        check("t3 issued", 64'(issued), 64'd0);
        check("t3 n_done", 64'(n_done), 64'd1);

        // Abort coinciding with the third accepted beat; a start while busy is ignored.
        clear_obs();
        step(1'b1, 32'h3000, 8'd8, 16'h10, 1'b0, 1'b1);
        step(1'b1, 32'h9999, 8'd2, 16'h1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b1, 1'b1);
        check("t4 aborted", 64'(aborted), 64'd1);
        check("t4 busy", 64'(busy), 64'd0);
        idle(4);
        exp_q = '{32'h3000, 32'h3010, 32'h3020};
        check_log("t4");
        check("t4 n_abort", 64'(n_abort), 64'd1);
        check("t4 n_done", 64'(n_done), 64'd0);
        check("t4 issued", 64'(issued), 64'd3);

        // Sequence crossing the top of the address space.
        clear_obs();
        step(1'b1, 32'hFFFF_FFF8, 8'd4, 16'd4, 1'b0, 1'b1);
        idle(6);
`ifdef FETCH_OVF_CHK_EN
        check("t5 n_err", 64'(n_err), 64'd1);
        check("t5 err_cyc", 64'(err_cyc), 64'd1);
        check("t5 n_valid", 64'(n_valid), 64'd0);
        check("t5 n_done", 64'(n_done), 64'd0);
`else
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        check_log("t5");
        check("t5 n_err", 64'(n_err), 64'd0);
        check("t5 n_done", 64'(n_done), 64'd1);
`endif

        // Reset in the middle of a sequence, then a clean two-beat run.
        clear_obs();
        step(1'b1, 32'h4000, 8'd8, 16'd4, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h0, 16'h0, 1'b0, 1'b1);
        do_reset();
        clear_obs();
        step(1'b1, 32'h5000, 8'd2, 16'd8, 1'b0, 1'b1);
        idle(4);
        exp_q = '{32'h5000, 32'h5008};
        check_log("t6");
        check("t6 done_cyc", 64'(done_cyc), 64'd3);
        check("t6 issued", 64'(issued), 64'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            s   = ($urandom_range(0, 7) == 0);
            b   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : 32'($urandom);
            c   = ($urandom_range(0, 49) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            st  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 64)) : 16'($urandom);
            ab  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            step(s, b, c, st, ab, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mbox_fetch_sequencer.md
# mbox_fetch_sequencer

Parametrised multi-beat address sequencer for the message-box fetch path. A single start pulse latches a base address, beat count and byte stride. The block then issues one address per beat on a valid/ready request channel and pulses `done` when the programmed sequence completes. It sits between the mailbox command decoder and the bus read master, and adds backpressure, programmable stride, abort and a progress counter.

## Interface
Parameters:
- `ADDR_W`, 32: address width in bits.
- `CNT_W`, 8: beat-count width in bits; maximum sequence length is 2^CNT_W-1 beats.
- `STRIDE_W`, 16: stride width in bits; stride is an unsigned byte increment.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  start request; accepted only in IDLE.
- `base_addr`  in  ADDR_W  first address; sampled on accepted start.
- `fetch_count`  in  CNT_W  number of beats; sampled on accepted start.
- `stride`  in  STRIDE_W  byte increment per beat; sampled on accepted start.
- `abort`  in  1  terminates the sequence in progress.
- `req_valid`  out  1  `req_addr` is valid.
- `req_ready`  in  1  downstream accepts the current beat.
- `req_addr`  out  ADDR_W  current beat address.
- `issued`  out  CNT_W  beats accepted so far in the current or most recent sequence.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes normally.
- `aborted`  out  1  one-cycle pulse when a sequence is terminated by `abort`.
- `err`  out  1  one-cycle pulse when a start is rejected (only when `FETCH_OVF_CHK_EN` is defined).

## Operation
- States: IDLE, ISSUE, FIN.
- **IDLE**
  - `start`=1 latches `base_addr`, `fetch_count` and `stride`, and clears `issued`.
  - If `fetch_count`≠0, go to ISSUE. If `fetch_count`=0, go to FIN.
- **ISSUE**
  - `req_valid`=1 and `req_addr`=base+issued×stride.
  - A beat is accepted in any cycle with `req_valid` && `req_ready`. On acceptance, `issued`+=1 and `req_addr`+=stride.
  - The last accepted beat (`issued` reaching `fetch_count`) moves the block to FIN.
- **FIN**: lasts one cycle with `done`=1, then returns to IDLE.
- **Abort** in ISSUE:
  - Go to IDLE next cycle; `aborted` pulses for one cycle and `done` is not asserted.
  - A beat handshaked in the same cycle as `abort` still counts in `issued`.
  - `abort` outside ISSUE is ignored.
- `start` while `busy`=1 is ignored; the latched parameters are unchanged.
- Address arithmetic is modulo 2^ADDR_W; stride is zero-extended to ADDR_W.
- `req_addr` and `req_valid` hold stable while `req_valid`=1 and `req_ready`=0 (AXI-style hold).
- `issued` holds its final value in IDLE until the next accepted start.

## Timing
- Reset values: `req_valid`=0, `req_addr`=0, `issued`=0, `busy`=0, `done`=0, `aborted`=0, `err`=0. State is IDLE.
- Reset mid-sequence returns to these values immediately; no `done` or `aborted` pulse is produced.
- Start to first `req_valid`: 1 cycle, i.e. `start` sampled at edge N gives `req_valid` high after edge N.
- With `req_ready` tied high: 1 beat per cycle, and `done` rises the cycle after the last beat.
- Total latency for count C with no backpressure: start edge to `done` high is C+1 cycles. For C=0 it is 1 cycle.
- `busy` is high in ISSUE and FIN.
- A new start is accepted the cycle after `done` (IDLE).
- All outputs are registered; there is no combinational path from `req_ready` to `req_valid`.

## Configuration
- `FETCH_OVF_CHK_EN` defined:
  - On start, compute last = base+(count-1)×stride at full precision.
  - If last > 2^ADDR_W-1, reject the start: stay in IDLE, `err` pulses one cycle after `start`, and no `done`.
  - count=0 is never rejected.
- `FETCH_OVF_CHK_EN` undefined:
  - No check is made; addresses wrap modulo 2^ADDR_W.
  - `err` is tied to 0.

## Test plan
- base=0x1000, count=4, stride=4, `req_ready`=1 → `req_addr` 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; `done` on cycle 5; `issued`=4.
- Same sequence with `req_ready` low for 3 cycles on beat 2 → `req_addr` holds 0x1004 while stalled; sequence completes with 4 beats and `done` once.
- count=0, base=0x2000 → no `req_valid`; `done` pulses 1 cycle after start; `issued`=0.
- count=8, stride=0x10, `abort` asserted together with an accepted 3rd beat → `aborted` pulse, no `done`, `issued`=3, IDLE next cycle; a second `start` while busy has no effect.
- base=0xFFFF_FFF8, count=4, stride=4:
  - `FETCH_OVF_CHK_EN` undefined → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
  - `FETCH_OVF_CHK_EN` defined → `err` pulse, no `req_valid`.
- `rst_n` low while in ISSUE → all outputs 0 asynchronously; after release, a new start with count=2 runs normally.
